// File: rtl/tx_frame_encoder.sv
// Two-stage TX frame encoder: stage 1 inserts a CRC-12 (covering an implicit
// frame sequence ID for data frames), stage 2 self-synchronously scrambles the body.
module tx_frame_encoder #(
    parameter int FRAME_WIDTH    = 256,
    parameter int PAYLOAD_WIDTH  = 240,
    parameter int FRAME_ID_WIDTH = 8,
    parameter int SCRAMBLE       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FRAME_WIDTH-1:0]    tx_frame_in,
    input  logic                      crc_err_inject,
    output logic [FRAME_WIDTH-1:0]    tx_frame_out,
    output logic [FRAME_ID_WIDTH-1:0] frame_id,
    output logic                      hdr_err
);

    localparam int CRC_WIDTH  = FRAME_WIDTH - PAYLOAD_WIDTH - 4;
    localparam int MSG_WIDTH  = FRAME_ID_WIDTH + FRAME_WIDTH - CRC_WIDTH;
    localparam int BODY_WIDTH = FRAME_WIDTH - 2;
    localparam int SCR_WIDTH  = 58;

    localparam logic [CRC_WIDTH-1:0]   CRC_POLY    = 12'h80F;
    localparam logic [FRAME_WIDTH-1:0] RESET_FRAME = {2'b10, {(FRAME_WIDTH-2){1'b0}}};

    generate
        if (CRC_WIDTH != 12) begin : g_bad_crc_width
            $error("tx_frame_encoder: FRAME_WIDTH-PAYLOAD_WIDTH-4 must equal 12");
        end
    endgenerate

    // Bit-serial MSB-first CRC, unrolled into a single cycle.
    function automatic logic [CRC_WIDTH-1:0] crc_calc(input logic [MSG_WIDTH-1:0] msg);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = '1;
        for (int i = MSG_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ msg[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // Returns {next_state, scrambled_body}; body is processed from its MSB down.
    function automatic logic [SCR_WIDTH+BODY_WIDTH-1:0] scramble(
        input logic [BODY_WIDTH-1:0] body,
        input logic [SCR_WIDTH-1:0]  state
    );
        logic [SCR_WIDTH-1:0]  s;
        logic [BODY_WIDTH-1:0] o;
        logic                  b;
        s = state;
        o = body;
        for (int i = BODY_WIDTH - 1; i >= 0; i--) begin
            b    = body[i] ^ s[38] ^ s[57];
            o[i] = b;
            s    = {s[56:0], b};
        end
        return {s, o};
    endfunction

    logic [FRAME_WIDTH-1:0]    s1_frame_q, s1_frame_d;
    logic                      s1_hdr_err_q, s1_hdr_err_d;
    logic                      s1_valid_q;
    logic [FRAME_ID_WIDTH-1:0] frame_id_q, frame_id_d;
    logic [FRAME_WIDTH-1:0]    out_q, out_d;
    logic                      hdr_err_q;
    logic [SCR_WIDTH-1:0]      scr_q, scr_d;

    logic [1:0]                hdr_in;
    logic                      is_data;
    logic [FRAME_ID_WIDTH-1:0] id_field;
    logic [CRC_WIDTH-1:0]      crc_val;

    always_comb begin
        hdr_in       = tx_frame_in[FRAME_WIDTH-1:FRAME_WIDTH-2];
        is_data      = (hdr_in == 2'b01);
        id_field     = is_data ? frame_id_q : '0;
        crc_val      = crc_calc({id_field, tx_frame_in[FRAME_WIDTH-1:CRC_WIDTH]});
        crc_val[0]   = crc_val[0] ^ crc_err_inject;
        s1_frame_d   = {tx_frame_in[FRAME_WIDTH-1:CRC_WIDTH], crc_val};
        s1_hdr_err_d = (hdr_in[1] == hdr_in[0]);
        frame_id_d   = is_data ? frame_id_q + 1'b1 : frame_id_q;
    end

    // The reset frame held in stage 1 bypasses the scrambler and leaves its
    // state untouched, so the first real frame after reset starts from all ones.
    generate
        if (SCRAMBLE != 0) begin : g_scramble
            logic [SCR_WIDTH+BODY_WIDTH-1:0] scr_result;
            always_comb begin
                scr_result = scramble(s1_frame_q[BODY_WIDTH-1:0], scr_q);
                out_d      = s1_frame_q;
                scr_d      = scr_q;
                if (s1_valid_q) begin
                    out_d[BODY_WIDTH-1:0] = scr_result[BODY_WIDTH-1:0];
                    scr_d                 = scr_result[SCR_WIDTH+BODY_WIDTH-1:BODY_WIDTH];
                end
            end
        end else begin : g_bypass
            assign out_d = s1_frame_q;
            assign scr_d = scr_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_frame_q   <= RESET_FRAME;
            s1_hdr_err_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            frame_id_q   <= '0;
            out_q        <= RESET_FRAME;
            hdr_err_q    <= 1'b0;
            scr_q        <= '1;
        end else begin
            s1_frame_q   <= s1_frame_d;
            s1_hdr_err_q <= s1_hdr_err_d;
            s1_valid_q   <= 1'b1;
            frame_id_q   <= frame_id_d;
            out_q        <= out_d;
            hdr_err_q    <= s1_hdr_err_q & s1_valid_q;
            scr_q        <= scr_d;
        end
    end

    assign tx_frame_out = out_q;
    assign frame_id     = frame_id_q;
    assign hdr_err      = hdr_err_q;

endmodule

// File: tb/tb_tx_frame_encoder.sv
// Randomized bench for tx_frame_encoder: a transaction-level model (polynomial
// long division CRC, bit-stream scrambler history) predicts every output cycle.
module tb_tx_frame_encoder;

    localparam int FW = 256;
    localparam int IW = 8;
    localparam int CW = 12;
    localparam int MW = IW + FW - CW;
    localparam logic [FW-1:0] RESET_FRAME = {2'b10, 254'b0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] tx_in = '0;
    logic          inj = 1'b0;
    logic [FW-1:0] out_s, out_n;
    logic [IW-1:0] id_s, id_n;
    logic          hdr_s, hdr_n;

    tx_frame_encoder #(.SCRAMBLE(1)) dut (
        .clk(clk), .rst(rst), .tx_frame_in(tx_in), .crc_err_inject(inj),
        .tx_frame_out(out_s), .frame_id(id_s), .hdr_err(hdr_s)
    );

    tx_frame_encoder #(.SCRAMBLE(0)) dut_ns (
        .clk(clk), .rst(rst), .tx_frame_in(tx_in), .crc_err_inject(inj),
        .tx_frame_out(out_n), .frame_id(id_n), .hdr_err(hdr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] scr;
        logic [FW-1:0] plain;
        logic [FW-1:0] plain_ni;
        logic          hdr;
        logic          is_rst;
        logic          inj;
    } exp_t;

    exp_t          exp_q[$];
    bit            tx_hist[$];
    bit            rx_hist[$];
    logic [IW-1:0] model_id = '0;
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Remainder of (M*x^12 + init*x^len) mod P via long division.
    function automatic logic [CW-1:0] crc_model(input logic [MW-1:0] msg);
        logic [MW+CW-1:0] r;
        r = {msg, 12'h000};
        r[MW+CW-1:MW] = r[MW+CW-1:MW] ^ 12'hFFF;
        for (int i = MW + CW - 1; i >= CW; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h180F;
        end
        return r[CW-1:0];
    endfunction

    function automatic void reseed_tx();
        tx_hist.delete();
        for (int i = 0; i < 58; i++) tx_hist.push_back(1'b1);
    endfunction

    function automatic void reseed_rx();
        rx_hist.delete();
        for (int i = 0; i < 58; i++) rx_hist.push_back(1'b1);
    endfunction

    function automatic logic [FW-1:0] scramble(input logic [FW-1:0] p);
        logic [FW-1:0] o;
        bit            b;
        int            n;
        o = p;
        for (int i = FW - 3; i >= 0; i--) begin
            n = tx_hist.size();
            b = p[i] ^ tx_hist[n-39] ^ tx_hist[n-58];
            o[i] = b;
            tx_hist.push_back(b);
            void'(tx_hist.pop_front());
        end
        return o;
    endfunction

    function automatic logic [FW-1:0] descramble(input logic [FW-1:0] c);
        logic [FW-1:0] d;
        int            n;
        d = c;
        for (int i = FW - 3; i >= 0; i--) begin
            n = rx_hist.size();
            d[i] = c[i] ^ rx_hist[n-39] ^ rx_hist[n-58];
            rx_hist.push_back(c[i]);
            void'(rx_hist.pop_front());
        end
        return d;
    endfunction

    function automatic exp_t model_frame(input logic [FW-1:0] f, input logic fi);
        exp_t          e;
        logic [1:0]    h;
        logic [IW-1:0] idf;
        logic [CW-1:0] c;
        h          = f[FW-1:FW-2];
        idf        = (h == 2'b01) ? model_id : '0;
        c          = crc_model({idf, f[FW-1:CW]});
        e.plain_ni = {f[FW-1:CW], c};
        e.plain    = e.plain_ni ^ FW'(fi);
        e.scr      = scramble(e.plain);
        e.hdr      = (h == 2'b00) || (h == 2'b11);
        e.is_rst   = 1'b0;
        e.inj      = fi;
        if (h == 2'b01) model_id = IW'((int'(model_id) + 1) % 256);
        return e;
    endfunction

    function automatic logic [FW-1:0] rand_frame(input logic [1:0] h);
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        f[FW-1:FW-2] = h;
        return f;
    endfunction

    function automatic logic [1:0] rand_hdr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        if (r < 6) return 2'b01;
        return 2'b10;
    endfunction

    // Scoreboard: every posedge pushes the prediction for the sampled frame and
    // the output just after the edge must match the oldest prediction.
    initial begin
        exp_t          e;
        logic [FW-1:0] d;
        forever begin
            @(posedge clk);
            if (rst) begin
                model_id = '0;
                reseed_tx();
                exp_q.delete();
                e = '{RESET_FRAME, RESET_FRAME, RESET_FRAME, 1'b0, 1'b1, 1'b0};
                exp_q.push_back(e);
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(model_frame(tx_in, inj));
            end
            #1;
            e = exp_q.pop_front();
            check("out_scr", out_s, e.scr);
            check("out_noscr", out_n, e.plain);
            check("hdr_err", FW'(hdr_s), FW'(e.hdr));
            check("hdr_err_noscr", FW'(hdr_n), FW'(e.hdr));
            check("frame_id", FW'(id_s), FW'(model_id));
            check("frame_id_noscr", FW'(id_n), FW'(model_id));
            if (e.is_rst) begin
                reseed_rx();
            end else begin
                d = descramble(out_s);
                check("descrambled", d, e.plain);
                if (e.inj) check("inject_diff", d ^ e.plain_ni, FW'(1));
            end
        end
    end

    task automatic drive(input logic [FW-1:0] f, input logic fi);
        tx_in = f;
        inj   = fi;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst   = 1'b1;
        tx_in = rand_frame(2'b01);
        inj   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inj = 1'b0;
        check("rst_frame_id", FW'(id_s), FW'(0));
        check("rst_out", out_s, RESET_FRAME);
    endtask

    initial begin
        logic [FW-1:0] f;
        int            dc;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out", out_s, RESET_FRAME);
        check("reset_id", FW'(id_s), FW'(0));
        check("reset_hdr", FW'(hdr_s), FW'(0));

        // 300 data frames, payload = index, junk in the ignored CRC field.
        for (int i = 0; i < 300; i++) begin
            f = '0;
            f[FW-1:FW-2] = 2'b01;
            f[FW-3:CW] = (FW-2-CW)'(i);
            f[CW-1:0] = CW'($urandom);
            drive(f, 1'b0);
        end
        check("id_after_300", FW'(id_s), FW'(44));

        // Control frames interleaved with data; inject on the 5th data frame.
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 1) begin
                f = rand_frame(2'b10);
                f[FW-3:FW-18] = 16'h0001;
                drive(f, 1'b0);
            end else begin
                drive(rand_frame(2'b01), dc == 4);
                dc++;
            end
        end
        check("id_after_mix", FW'(id_s), FW'(64));

        // Invalid headers, one combined with inject.
        drive(rand_frame(2'b11), 1'b0);
        drive(rand_frame(2'b00), 1'b1);
        drive(rand_frame(2'b10), 1'b0);
        check("id_after_invalid", FW'(id_s), FW'(64));

        for (int i = 0; i < 30; i++) drive(rand_frame(rand_hdr()), $urandom_range(0, 9) == 0);

        pulse_reset();
        for (int i = 0; i < 20; i++) drive(rand_frame(2'b01), 1'b0);
        check("id_after_reset_run", FW'(id_s), FW'(20));

        for (int i = 0; i < 40; i++) drive(rand_frame(rand_hdr()), $urandom_range(0, 7) == 0);
        for (int i = 0; i < 3; i++) drive(rand_frame(2'b10), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
